// File: rtl/up_sample.sv
`default_nettype none
// ============================================================================
//  Module   : up_sample
//  Purpose  : Frame-rate expander. Captures one FRAME_LEN-word frame into a
//             ping-pong buffer and replays it REPEAT times as one continuous
//             burst. Words whose bit 31 (sample-valid) is clear leave as zero.
//  Option   : UP_SAMPLE_ZERO_STUFF_EN - repetitions 1..REPEAT-1 emit zeros
//             (zero-stuffing interpolation) instead of replaying the frame.
//  Revision : 1.0 - initial release
// ============================================================================
module up_sample #(
  parameter int FRAME_LEN = 80,
  parameter int REPEAT    = 10,
  parameter int AW        = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        busy,
  output logic        overflow
);

  localparam int                c_MEM_W   = $clog2(2 * FRAME_LEN);
  localparam int                c_REP_W   = $clog2(REPEAT + 1);
  localparam logic [AW-1:0]     c_LAST    = AW'(FRAME_LEN - 1);
  localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  // Storage: bank 0 at [0, FRAME_LEN), bank 1 at [FRAME_LEN, 2*FRAME_LEN)
  logic [31:0]         r_mem [2*FRAME_LEN];

  logic [AW-1:0]       r_wr_cnt;
  logic                r_wr_bank;
  logic [1:0]          r_full;
  logic                r_overflow;

  state_t              r_state;
  logic [AW-1:0]       r_rd_addr;
  logic [c_REP_W-1:0]  r_rep;
  logic                r_rd_bank;
  logic                r_busy;

  logic [31:0]         r_data_out;
  logic                r_valid_out;

  logic                w_wr_en;
  logic                w_wr_last;
  logic                w_wr_drop;
  logic [c_MEM_W-1:0]  w_wr_addr;
  logic [c_MEM_W-1:0]  w_rd_addr;
  logic [31:0]         w_rd_word;
  logic                w_rd_wrap;
  logic                w_rd_done;
  logic                w_stuff;

  // A word is only stored into a bank that is not waiting to be replayed.
  // The full flag is sampled before this edge's update, so a bank freed on
  // the same edge only becomes writable one cycle later.
  assign w_wr_en   = valid_in & ~r_full[r_wr_bank];
  assign w_wr_drop = valid_in &  r_full[r_wr_bank];
  assign w_wr_last = (r_wr_cnt == c_LAST);
  assign w_wr_addr = c_MEM_W'(r_wr_cnt)
                   + (r_wr_bank ? c_MEM_W'(FRAME_LEN) : c_MEM_W'(0));

  assign w_rd_addr = c_MEM_W'(r_rd_addr)
                   + (r_rd_bank ? c_MEM_W'(FRAME_LEN) : c_MEM_W'(0));
  assign w_rd_word = r_mem[w_rd_addr];
  assign w_rd_wrap = (r_state == S_PLAY) && (r_rd_addr == c_LAST);
  assign w_rd_done = w_rd_wrap && (r_rep == c_REP_LAST);

`ifdef UP_SAMPLE_ZERO_STUFF_EN
  // Only the first repetition carries samples; the rest are zero-stuffed.
  assign w_stuff = (r_rep != '0);
`else
  assign w_stuff = 1'b0;
`endif

  // Frame buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= data_in;
    end
  end

  // Write-side word counter, bank select and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_cnt   <= '0;
      r_wr_bank  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_wr_en) begin
        if (w_wr_last) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + AW'(1);
        end
      end
    end
  end

  // Bank-full flags: set by the writer on frame completion, cleared by the
  // reader after the last repetition. Writer sets only an empty bank and the
  // reader clears only a full one, so both never touch the same bit at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 2'b00;
    end else begin
      if (w_wr_en && w_wr_last) begin
        r_full[r_wr_bank] <= 1'b1;
      end
      if (w_rd_done) begin
        r_full[r_rd_bank] <= 1'b0;
      end
    end
  end

  // Read FSM: waits for a full bank, then walks it REPEAT times.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
      r_rep     <= '0;
      r_rd_bank <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_state   <= S_PLAY;
            r_rd_addr <= '0;
            r_rep     <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_PLAY: begin
          if (w_rd_wrap) begin
            r_rd_addr <= '0;
            r_rep     <= r_rep + c_REP_W'(1);
            if (w_rd_done) begin
              r_rd_bank <= ~r_rd_bank;
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
            end
          end else begin
            r_rd_addr <= r_rd_addr + AW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: one word per PLAY cycle, invalid samples forced to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= (r_state == S_PLAY);
      if ((r_state == S_PLAY) && w_rd_word[31] && !w_stuff) begin
        r_data_out <= w_rd_word;
      end else begin
        r_data_out <= '0;
      end
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign busy      = r_busy;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_up_sample.sv
`default_nettype none
// ============================================================================
//  Module   : tb_up_sample
//  Purpose  : Self-checking bench for up_sample. Stimulus pushes expected
//             output words into a queue; a monitor pops and compares them
//             whenever valid_out is high, and also checks burst lengths.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_up_sample;

  localparam int FRAME_LEN = 80;
  localparam int REPEAT    = 10;
  localparam int AW        = 7;
  localparam int BURST     = FRAME_LEN * REPEAT;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic        valid_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        busy;
  logic        overflow;

  int          checks;
  int          failures;
  logic [31:0] sb[$];
  int          run_len;
  int          busy_len;

  up_sample #(
    .FRAME_LEN(FRAME_LEN),
    .REPEAT   (REPEAT),
    .AW       (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Input word i of a frame; kind 1 clears the valid flag on odd words.
  function automatic logic [31:0] in_word(input int kind, input int base, input int i);
    logic flag;
    flag = (kind == 0) ? 1'b1 : ((i % 2) == 0);
    return {flag, 31'(base + i)};
  endfunction

  // Expected output for word i in repetition r.
  function automatic logic [31:0] out_word(input int kind, input int base, input int i, input int r);
    logic [31:0] w;
    w = in_word(kind, base, i);
`ifdef UP_SAMPLE_ZERO_STUFF_EN
    if (r != 0) return 32'h0;
`else
    if (r < 0) return 32'h0;
`endif
    return w[31] ? w : 32'h0;
  endfunction

  task automatic push_expected(input int kind, input int base);
    for (int r = 0; r < REPEAT; r++)
      for (int i = 0; i < FRAME_LEN; i++)
        sb.push_back(out_word(kind, base, i, r));
  endtask

  // Called at posedge+1; returns at posedge+1 right after the last word's edge.
  task automatic send_frame(input int kind, input int base, input bit gappy);
    for (int i = 0; i < FRAME_LEN; i++) begin
      data_in  = in_word(kind, base, i);
      valid_in = 1'b1;
      @(posedge clk); #1;
      if (gappy) begin
        valid_in = 1'b0;
        data_in  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
      end
    end
    valid_in = 1'b0;
    data_in  = 32'h0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !valid_out && !busy) done = 1'b1;
    end
    check("drain_done", 32'(done), 32'd1);
    check("drain_queue_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_data_out", data_out, 32'h0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: scoreboard compare plus burst-length checks on valid_out and busy.
  always @(negedge clk) begin
    if (!rst) begin
      run_len  = 0;
      busy_len = 0;
    end else begin
      if (valid_out) begin
        if (sb.size() == 0) begin
          check("unexpected_output", data_out, 32'hFFFF_FFFF);
        end else begin
          check("data_out", data_out, sb.pop_front());
        end
        run_len++;
      end else if (run_len != 0) begin
        check("burst_len", 32'(run_len), 32'(BURST));
        run_len = 0;
      end
      if (busy) begin
        busy_len++;
      end else if (busy_len != 0) begin
        check("busy_len", 32'(busy_len), 32'(BURST));
        busy_len = 0;
      end
    end
  end

  initial begin
    int  gap;
    bit  seen;
    checks   = 0;
    failures = 0;
    run_len  = 0;
    busy_len = 0;
    rst      = 1'b0;
    valid_in = 1'b0;
    data_in  = 32'h0;

    // 1: ramp frame, latency and first word
    do_reset();
    push_expected(0, 0);
    send_frame(0, 0, 1'b0);
    check("lat_edge_t_valid", 32'(valid_out), 32'd0);
    @(posedge clk); #1;
    check("lat_t1_busy", 32'(busy), 32'd1);
    check("lat_t1_valid", 32'(valid_out), 32'd0);
    @(posedge clk); #1;
    check("lat_t2_valid", 32'(valid_out), 32'd1);
    check("lat_t2_data", data_out, 32'h8000_0000);
    wait_drain();
    check("t1_overflow", 32'(overflow), 32'd0);

    // 2: odd words flagged invalid
    push_expected(1, 32'h100);
    send_frame(1, 32'h100, 1'b0);
    wait_drain();

    // 3: three back-to-back frames, third dropped
    do_reset();
    push_expected(0, 32'h1000);
    push_expected(0, 32'h2000);
    send_frame(0, 32'h1000, 1'b0);
    send_frame(0, 32'h2000, 1'b0);
    send_frame(0, 32'h3000, 1'b0);
    check("t3_overflow_set", 32'(overflow), 32'd1);
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      if (!valid_out) seen = 1'b1;
    end
    check("t3_first_burst_end", 32'(seen), 32'd1);
    gap = 1;
    for (int n = 0; n < 10 && !valid_out; n++) begin
      @(negedge clk);
      if (!valid_out) gap++;
    end
    check("t3_gap_cycles", 32'(gap), 32'd1);
    wait_drain();
    check("t3_overflow_sticky", 32'(overflow), 32'd1);

    // 4: reset at replay cycle 300, then a fresh frame
    push_expected(0, 32'h4000);
    send_frame(0, 32'h4000, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (valid_out) seen = 1'b1;
    end
    check("t4_replay_started", 32'(seen), 32'd1);
    repeat (299) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    #1;
    check("t4_rst_valid", 32'(valid_out), 32'd0);
    check("t4_rst_data", data_out, 32'h0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_overflow", 32'(overflow), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    push_expected(0, 32'h5000);
    send_frame(0, 32'h5000, 1'b0);
    wait_drain();
    check("t4_overflow", 32'(overflow), 32'd0);

    // 5: valid_in toggling during capture
    push_expected(0, 0);
    send_frame(0, 0, 1'b1);
    wait_drain();
    check("t5_overflow", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/up_sample.md
Name: up_sample

Overview:
- Frame-rate expander: the transmit-direction counterpart of the team's frame down-sampler.
- Collects one frame of FRAME_LEN 32-bit words and replays it REPEAT times as a continuous output burst, restoring the original frame rate.
- Bit 31 of each word is the sample-valid flag; flagged-invalid words are emitted as 32'b0.
- Ping-pong buffered, so the next frame can be captured while the current one is replayed.

Parameters:
- FRAME_LEN, 80, words per frame.
- REPEAT, 10, output repetitions per captured frame (>=1).
- AW, 7, address width; 2^AW >= FRAME_LEN.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- data_in  input  32  input word; bit31 = sample-valid flag
- valid_in  input  1  data_in qualifier, one word per cycle
- data_out  output  32  replayed word, or 32'b0 if the stored bit31 = 0
- valid_out  output  1  data_out qualifier
- busy  output  1  high while the read FSM is in PLAY
- overflow  output  1  sticky: an input word was dropped because both banks were full

Behaviour:
- Reset (rst low, async): data_out=0, valid_out=0, busy=0, overflow=0, wr_cnt=0, wr_bank=0, rd_bank=0, both bank-full flags=0, FSM=IDLE. Any partial frame is discarded. Reset mid-replay aborts at once; buffer contents are don't-care.
- Storage: 2*FRAME_LEN x 32 register array or distributed RAM. Bank b occupies addresses b*FRAME_LEN .. b*FRAME_LEN+FRAME_LEN-1.
- Write side:
  - On valid_in=1 with full[wr_bank]=0: store data_in at wr_bank*FRAME_LEN+wr_cnt, then wr_cnt++.
  - When wr_cnt==FRAME_LEN-1 and a word is stored: wr_cnt<=0, full[wr_bank]<=1, wr_bank toggles.
  - On valid_in=1 with full[wr_bank]=1: word dropped, wr_cnt unchanged, overflow<=1 (cleared only by reset).
  - valid_in=0: no change.
- Read FSM:
  - IDLE: valid_out=0, busy=0. If full[rd_bank]=1: go to PLAY with rd_addr=0, rep=0.
  - PLAY: busy=1. Each cycle, read word at rd_bank*FRAME_LEN+rd_addr, then rd_addr++.
    - At rd_addr==FRAME_LEN-1: rd_addr<=0, rep++.
    - If additionally rep==REPEAT-1: full[rd_bank]<=0, rd_bank toggles, go to IDLE.
- Output register: valid_out and data_out are registered one cycle after the PLAY read.
  - data_out = word if word[31]=1, else 32'b0; valid_out=1.
  - Each burst is exactly FRAME_LEN*REPEAT consecutive valid_out cycles, with no gaps inside a burst.
  - Back-to-back frames are separated by exactly one valid_out=0 cycle (the IDLE cycle).
- Latency:
  - Last word of a frame sampled at edge T, so full set at T.
  - FSM enters PLAY at edge T+1.
  - First valid_out=1 at edge T+2.
- Simultaneous events:
  - Read side clears full[x] on the same edge the write side finds full[x]=1: that word is dropped (overflow set). A freed bank becomes writable the following cycle.
  - Writing into bank A while PLAY reads bank B is always legal; the banks never alias.
- Arithmetic: wr_cnt, rd_addr are AW bits; rep is ceil(log2(REPEAT+1)) bits. All compares are exact equality to the parameter value minus 1; no wrap beyond FRAME_LEN.

Optional Feature:
- Macro: UP_SAMPLE_ZERO_STUFF_EN.
- Defined (zero-stuffing interpolation): repetition 0 outputs the stored frame as above. Repetitions 1..REPEAT-1 output data_out=32'b0 with valid_out=1. Burst length and timing are unchanged.
- Undefined: every repetition replays the stored frame.

Test Plan:
- Reset, then 80 words data_in={1'b1,31'(i)}, i=0..79, valid_in continuous -> first valid_out 2 cycles after word 79. Exactly 800 valid_out cycles; data_out sequence 0x80000000..0x8000004F repeated 10 times; busy high for 800 cycles; overflow=0.
- Frame with odd i carrying bit31=0 -> data_out=0 at every odd position in all 10 repetitions; even positions pass through unchanged.
- Three frames back-to-back, no gaps -> frame 2 is captured during frame 1 replay and frame 3 is dropped (banks full) -> overflow=1 and stays 1. Frames 1 and 2 are each replayed 800 cycles, separated by one valid_out=0 cycle.
- Assert rst low at replay cycle 300, release, send a new frame -> outputs 0 during reset; the new frame replays from word 0 with full 800-cycle count; overflow=0.
- valid_in toggled 1/0 every cycle during capture (160 cycles for 80 words) -> stored and replayed contents match the gap-free case.
- With UP_SAMPLE_ZERO_STUFF_EN defined, one ramp frame -> cycles 0..79 show the ramp; cycles 80..799 show data_out=0 with valid_out=1.
